// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data RAM port arbiter: pick codes and
// starvation counter sizing.
package mem_arb_pkg;

    typedef logic [1:0] pick_t;

    localparam pick_t PICK_NONE  = 2'd0;
    localparam pick_t PICK_FETCH = 2'd1;
    localparam pick_t PICK_DATA  = 2'd2;

    localparam int unsigned STARVE_W           = 4;
    localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational requester selection: data first, unless fetch has waited
// through the maximum run of data grants.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic  if_req,
    input  logic  d_req,
    input  logic  starve_at_max,
    output pick_t pick
);

    always_comb begin
        pick = PICK_NONE;
        if (d_req && !(if_req && starve_at_max)) begin
            pick = PICK_DATA;
        end else if (if_req) begin
            pick = PICK_FETCH;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store unit, with
// a one-cycle registered read response per requester.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    localparam logic [STARVE_W-1:0] StarveMaxC = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    pick_t pick;
    logic  starve_at_max;

    assign starve_at_max = (starve_q == StarveMaxC);

    mem_arb_pick u_pick (
        .if_req        (if_req),
        .d_req         (d_req),
        .starve_at_max (starve_at_max),
        .pick          (pick)
    );

    // Grants are masked while reset is held so the RAM never sees a write.
    always_comb begin
        if_gnt        = reset_n && (pick == PICK_FETCH);
        d_gnt         = reset_n && (pick == PICK_DATA);
        ram_load      = d_gnt && d_we;
        ram_writedata = reset_n ? d_wdata : '0;
        if (!reset_n) begin
            ram_address = '0;
        end else if (d_gnt) begin
            ram_address = d_addr;
        end else begin
            ram_address = if_addr;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (d_gnt && !starve_at_max) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Read data is captured at the grant edge; rdata holds between responses.
    always_comb begin
        if_rvalid_d = if_gnt;
        if_rdata_d  = if_gnt ? ram_out : if_rdata_q;
        d_rvalid_d  = d_gnt;
        d_rdata_d   = d_rdata_q;
        if (d_gnt) begin
            d_rdata_d = d_we ? '0 : ram_out;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_q    <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            starve_q    <= starve_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;

    grant_onehot_a: assert property (@(posedge clock) disable iff (!reset_n)
        !(if_gnt && d_gnt));

    starve_bound_a: assert property (@(posedge clock) disable iff (!reset_n)
        starve_q <= StarveMaxC);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// model of arbitration, RAM contents and response timing.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SMAX = 4;

    logic          clock;
    logic          reset_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_writedata;
    logic          ram_load;
    logic [DW-1:0] ram_out;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_gnt        (if_gnt),
        .if_rvalid     (if_rvalid),
        .if_rdata      (if_rdata),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_gnt         (d_gnt),
        .d_rvalid      (d_rvalid),
        .d_rdata       (d_rdata),
        .ram_address   (ram_address),
        .ram_writedata (ram_writedata),
        .ram_load      (ram_load),
        .ram_out       (ram_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bench-side RAM: combinational read, write at the rising edge.
    logic [DW-1:0] mem [0:63];
    logic          preload_we;
    logic [5:0]    preload_idx;
    logic [DW-1:0] preload_val;

    assign ram_out = mem[ram_address[5:0]];

    always @(posedge clock) begin
        if (preload_we) mem[preload_idx] <= preload_val;
        else if (ram_load) mem[ram_address[5:0]] <= ram_writedata;
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:63];
    int            data_wins;
    logic          exp_if_rv, exp_d_rv;
    logic [DW-1:0] exp_if_rd, exp_d_rd;
    logic          seen_if_gnt, seen_d_gnt, seen_ram_load;
    int            checks, failures;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_if_rv = 1'b0;
        exp_d_rv  = 1'b0;
        exp_if_rd = '0;
        exp_d_rd  = '0;
        data_wins = 0;
    endtask

    // One clock: check everything at the falling edge, advance model, return at edge+1.
    task automatic cycle();
        logic          fw, dw;
        logic [AW-1:0] exp_addr;
        @(negedge clock);
        seen_if_gnt   = if_gnt;
        seen_d_gnt    = d_gnt;
        seen_ram_load = ram_load;
        check_eq("if_rvalid", if_rvalid, exp_if_rv);
        check_eq("if_rdata", if_rdata, exp_if_rd);
        check_eq("d_rvalid", d_rvalid, exp_d_rv);
        check_eq("d_rdata", d_rdata, exp_d_rd);
        if (!reset_n) begin
            fw = 1'b0;
            dw = 1'b0;
            exp_addr = '0;
        end else begin
            // Fetch only beats a waiting data request once SMAX data wins piled up.
            fw = if_req && (!d_req || data_wins >= SMAX);
            dw = d_req && !fw;
            exp_addr = dw ? d_addr : if_addr;
        end
        check_eq("if_gnt", if_gnt, fw);
        check_eq("d_gnt", d_gnt, dw);
        check_eq("ram_load", ram_load, dw && d_we);
        check_eq("ram_address", ram_address, exp_addr);
        check_eq("ram_writedata", ram_writedata, reset_n ? d_wdata : '0);
        if (!reset_n) begin
            model_reset();
        end else begin
            exp_if_rv = fw;
            exp_d_rv  = dw;
            if (fw) exp_if_rd = ref_mem[if_addr[5:0]];
            if (dw) begin
                if (d_we) begin
                    exp_d_rd = '0;
                    ref_mem[d_addr[5:0]] = d_wdata;
                end else begin
                    exp_d_rd = ref_mem[d_addr[5:0]];
                end
            end
            if (!if_req || fw) data_wins = 0;
            else if (dw) data_wins = data_wins + 1;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        preload_we  = 1'b1;
        preload_idx = '0;
        preload_val = '0;
        model_reset();

        for (int i = 0; i < 64; i++) begin
            preload_idx = 6'(i);
            preload_val = (i == 16) ? 32'hDEAD_BEEF : $urandom;
            ref_mem[i]  = preload_val;
            @(posedge clock);
            #1;
        end
        preload_we = 1'b0;

        // Requests under reset must not be granted.
        if_req = 1'b1;
        d_req  = 1'b1;
        d_we   = 1'b1;
        cycle();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) cycle();
        check_eq("idle_if_rdata", if_rdata, 0);
        check_eq("idle_d_rdata", d_rdata, 0);

        // Fetch only.
        if_req  = 1'b1;
        if_addr = 32'h10;
        cycle();
        if_req = 1'b0;
        check_eq("dir_fetch_gnt", seen_if_gnt, 1);
        check_eq("dir_fetch_rvalid", if_rvalid, 1);
        check_eq("dir_fetch_rdata", if_rdata, 32'hDEAD_BEEF);

        // Store then load to the same word on consecutive cycles.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h20;
        d_wdata = 32'h1234_5678;
        cycle();
        check_eq("dir_store_gnt", seen_d_gnt, 1);
        check_eq("dir_store_load", seen_ram_load, 1);
        check_eq("dir_store_rvalid", d_rvalid, 1);
        check_eq("dir_store_rdata", d_rdata, 0);
        d_we = 1'b0;
        cycle();
        d_req = 1'b0;
        check_eq("dir_load_rvalid", d_rvalid, 1);
        check_eq("dir_load_rdata", d_rdata, 32'h1234_5678);

        // Continuous contention: D,D,D,D,F repeating.
        if_req  = 1'b1;
        if_addr = 32'h3;
        d_req   = 1'b1;
        d_addr  = 32'h7;
        for (int i = 0; i < 15; i++) begin
            cycle();
            check_eq("starve_d_gnt", seen_d_gnt, (i % 5) != 4);
            check_eq("starve_if_gnt", seen_if_gnt, (i % 5) == 4);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        cycle();

        // Alternating fetch and load: one response every cycle.
        for (int i = 0; i < 10; i++) begin
            if_req  = (i % 2) == 0;
            d_req   = (i % 2) == 1;
            if_addr = 32'(i);
            d_addr  = 32'(i + 16);
            cycle();
            check_eq("alt_rvalid", if_rvalid | d_rvalid, 1);
        end
        if_req = 1'b0;
        d_req  = 1'b0;

        // Reset while a load response is pending.
        d_req  = 1'b1;
        d_addr = 32'h5;
        cycle();
        d_req = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_mid_d_rvalid", d_rvalid, 0);
        cycle();
        reset_n = 1'b1;
        cycle();
        check_eq("rst_after_d_rvalid", d_rvalid, 0);
        cycle();
        if_req = 1'b1;
        d_req  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("rst_counter_if_gnt", seen_if_gnt, i == 4);
        end

        // Random traffic; requests are held until the model grants them.
        for (int n = 0; n < 600; n++) begin
            logic fw_done, dw_done;
            cycle();
            fw_done = seen_if_gnt;
            dw_done = seen_d_gnt;
            if (!if_req || fw_done) begin
                if_req  = $urandom_range(0, 3) != 0;
                if_addr = 32'($urandom_range(0, 15));
            end
            if (!d_req || dw_done) begin
                d_req   = $urandom_range(0, 2) != 0;
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = 32'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
